seg7_scan: RTL

Time-multiplexed 4-digit seven-segment driver for the score/timer display. Sits directly downstream of the binary-to-BCD converter. Latches the four BCD digits on the converter's completion strobe and scans them onto a common-anode display, with optional leading-zero blanking, per-digit decimal points and anti-ghosting dead time. Emits a once-per-frame tick, which the top level uses to launch the next conversion.

---
 rtl/seg7_scan.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Four-digit common-anode seven-segment scanner. Latches BCD digits on load and
// multiplexes them with a one-cycle dark gap between digit slots.
module seg7_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       blank_lz,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic {DARK, SHOW} phase_t;

  logic [PW-1:0]   pcnt_reg;
  logic [1:0]      idx_reg;
  logic [3:0][3:0] digit_reg;
  logic [3:0]      an_reg;
  logic [6:0]      seg_reg;
  logic            dp_reg;
  logic            frame_tick_reg;

  logic [3:0][3:0] bcd_in;
  logic [3:0][6:0] glyph;
  logic [3:1]      lead_zero;
  logic [3:0]      blank_vec;
  phase_t          phase;
  logic            slot_end;
  logic [3:0]      an_next;
  logic [6:0]      seg_next;
  logic            dp_next;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  assign bcd_in       = {bcd3, bcd2, bcd1, bcd0};
  assign lead_zero[3] = (digit_reg[3] == 4'd0);

  // A digit is a leading zero only if it and every digit above it are zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign glyph[gi] = decode(digit_reg[gi]);
    if (gi == 0) begin : g_units
      assign blank_vec[gi] = 1'b0;
    end else begin : g_upper
      if (gi < 3) begin : g_chain
        assign lead_zero[gi] = (digit_reg[gi] == 4'd0) && lead_zero[gi+1];
      end
      assign blank_vec[gi] = blank_lz & lead_zero[gi];
    end
  end

  assign phase    = (pcnt_reg == '0) ? DARK : SHOW;
  assign slot_end = (pcnt_reg == PCNT_MAX);

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (phase == SHOW) begin
      dp_next = ~dp_en[idx_reg];
      if (!blank_vec[idx_reg]) begin
        an_next  = ~(4'b0001 << idx_reg);
        seg_next = glyph[idx_reg];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_reg       <= '0;
      idx_reg        <= 2'd0;
      digit_reg      <= '0;
      an_reg         <= 4'b1111;
      seg_reg        <= 7'b1111111;
      dp_reg         <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      if (load) begin
        digit_reg <= bcd_in;
      end
      if (slot_end) begin
        pcnt_reg <= '0;
        idx_reg  <= idx_reg + 2'd1;
      end else begin
        pcnt_reg <= pcnt_reg + PW'(1);
      end
      frame_tick_reg <= slot_end && (idx_reg == 2'd3);
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule
